ascon_sched: RTL

ASCON_SCHED -- requirements
Module: ascon_sched

---
 rtl/ascon_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ascon_sched.sv
// Ascon-128 encryption control sequencer: walks init, AD absorption, PT absorption and
// finalisation, emitting one datapath strobe per cycle for an external permutation core.
module ascon_sched #(
  parameter int unsigned NB_AD = 1,
  parameter int unsigned NB_PT = 23
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       out_ready_i,
  output logic       load_init_o,
  output logic       round_en_o,
  output logic [3:0] round_cst_o,
  output logic       xor_key_tail_o,
  output logic       xor_ad_o,
  output logic [3:0] ad_idx_o,
  output logic       xor_domsep_o,
  output logic       xor_pt_o,
  output logic [4:0] pt_idx_o,
  output logic       cipher_valid_o,
  output logic       xor_key_fin_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StInitR, StKeyTail, StAdXor, StAdR,
    StDomsep, StPtXor, StPtR, StFinKey, StFinR, StTag
  } state_e;

  localparam logic [3:0] AdLast   = (NB_AD == 0) ? 4'd0 : 4'(NB_AD - 1);
  localparam logic [4:0] PtLast   = 5'(NB_PT - 1);
  localparam logic [3:0] RndLast  = 4'd11;
  localparam logic [3:0] RndHalf  = 4'd6;

  state_e     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] ad_q, ad_d;
  logic [4:0] pt_q, pt_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      rnd_q   <= '0;
      ad_q    <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      ad_q    <= ad_d;
      pt_q    <= pt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    ad_d    = ad_q;
    pt_d    = pt_q;
    unique case (state_q)
      StIdle: begin
        rnd_d = '0;
        ad_d  = '0;
        pt_d  = '0;
        if (start_i && !abort_i) state_d = StLoad;
      end
      StLoad: begin
        rnd_d   = '0;
        state_d = StInitR;
      end
      StInitR: begin
        if (rnd_q == RndLast) begin
          rnd_d   = '0;
          state_d = StKeyTail;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      StKeyTail: begin
        ad_d    = '0;
        state_d = (NB_AD == 0) ? StDomsep : StAdXor;
      end
      StAdXor: begin
        rnd_d   = RndHalf;
        state_d = StAdR;
      end
      StAdR: begin
        if (rnd_q == RndLast) begin
          rnd_d = '0;
          if (ad_q == AdLast) begin
            ad_d    = '0;
            state_d = StDomsep;
          end else begin
            ad_d    = ad_q + 4'd1;
            state_d = StAdXor;
          end
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      StDomsep: begin
        pt_d    = '0;
        state_d = StPtXor;
      end
      StPtXor: begin
        if (out_ready_i) begin
          if (pt_q == PtLast) begin
            pt_d    = '0;
            state_d = StFinKey;
          end else begin
            rnd_d   = RndHalf;
            state_d = StPtR;
          end
        end
      end
      StPtR: begin
        if (rnd_q == RndLast) begin
          rnd_d   = '0;
          pt_d    = pt_q + 5'd1;
          state_d = StPtXor;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      StFinKey: begin
        rnd_d   = '0;
        state_d = StFinR;
      end
      StFinR: begin
        if (rnd_q == RndLast) begin
          rnd_d   = '0;
          state_d = StTag;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      StTag: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides every transition, including a handshake completing this cycle.
    if (abort_i && state_q != StIdle) begin
      state_d = StIdle;
      rnd_d   = '0;
      ad_d    = '0;
      pt_d    = '0;
    end
  end

  always_comb begin
    load_init_o    = (state_q == StLoad);
    round_en_o     = (state_q == StInitR) || (state_q == StAdR) ||
                     (state_q == StPtR)   || (state_q == StFinR);
    round_cst_o    = round_en_o ? rnd_q : 4'd0;
    xor_key_tail_o = (state_q == StKeyTail);
    xor_ad_o       = (state_q == StAdXor);
    ad_idx_o       = xor_ad_o ? ad_q : 4'd0;
    xor_domsep_o   = (state_q == StDomsep);
    cipher_valid_o = (state_q == StPtXor);
    xor_pt_o       = cipher_valid_o && out_ready_i;
    pt_idx_o       = cipher_valid_o ? pt_q : 5'd0;
    xor_key_fin_o  = (state_q == StFinKey);
    tag_valid_o    = (state_q == StTag);
    busy_o         = (state_q != StIdle);
  end

endmodule
